// File: rtl/rc_pwm_capture.sv
// N-channel RC receiver pulse-width capture: synchronise, deglitch, measure high time
// in microsecond ticks, range-check, publish with strobe, and flag loss of signal.
module rc_pwm_capture #(
    parameter int NCH        = 4,
    parameter int CLK_DIV    = 25,
    parameter int FILT_LEN   = 4,
    parameter int MIN_US     = 800,
    parameter int MAX_US     = 2200,
    parameter int TIMEOUT_US = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    RC_IN,
    output logic [12*NCH-1:0] WIDTH,
    output logic [NCH-1:0]    NEW,
    output logic [NCH-1:0]    VALID,
    output logic              FAILSAFE
);

    localparam int               PRE_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_DIV - 1);
    localparam logic [3:0]       FILT_MAX  = 4'(FILT_LEN - 1);
    localparam logic [11:0]      MIN_W     = 12'(MIN_US);
    localparam logic [11:0]      MAX_W     = 12'(MAX_US);
    localparam logic [15:0]      TO_MAX    = 16'(TIMEOUT_US);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } ch_state_e;

    logic [PRE_W-1:0] presc_r;
    logic             tick_s;
    logic             failsafe_r;

    assign tick_s   = (presc_r == PRE_MAX);
    assign FAILSAFE = failsafe_r;

    // Shared microsecond prescaler
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Failsafe flag lags the channel valid bits by one cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            failsafe_r <= 1'b1;
        end else begin
            failsafe_r <= ~(&VALID);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic        sync1_r;
        logic        sync2_r;
        logic        filt_r;
        logic        filt_d_r;
        logic [3:0]  filt_cnt_r;
        logic        rise_s;
        logic        fall_s;
        ch_state_e   state_r;
        ch_state_e   state_s;
        logic [11:0] wcnt_r;
        logic [11:0] wcnt_s;
        logic [11:0] wcnt_inc_s;
        logic        accept_s;
        logic [15:0] to_cnt_r;
        logic [15:0] to_cnt_s;
        logic [11:0] width_r;
        logic        new_r;
        logic        valid_r;

        assign rise_s = filt_r & ~filt_d_r;
        assign fall_s = ~filt_r & filt_d_r;

        assign WIDTH[12*i +: 12] = width_r;
        assign NEW[i]            = new_r;
        assign VALID[i]          = valid_r;

        // Two-flop synchroniser followed by a run-length level filter
        always_ff @(posedge CLK) begin
            if (RST) begin
                sync1_r    <= 1'b0;
                sync2_r    <= 1'b0;
                filt_r     <= 1'b0;
                filt_d_r   <= 1'b0;
                filt_cnt_r <= 4'd0;
            end else begin
                sync1_r  <= RC_IN[i];
                sync2_r  <= sync1_r;
                filt_d_r <= filt_r;
                if (sync2_r == filt_r) begin
                    filt_cnt_r <= 4'd0;
                end else if (filt_cnt_r == FILT_MAX) begin
                    filt_r     <= ~filt_r;
                    filt_cnt_r <= 4'd0;
                end else begin
                    filt_cnt_r <= filt_cnt_r + 4'd1;
                end
            end
        end

        // Channel FSM next state, width counting and acceptance decision
        always_comb begin
            state_s    = state_r;
            wcnt_s     = wcnt_r;
            accept_s   = 1'b0;
            // a tick landing on the fall cycle still belongs to the pulse
            wcnt_inc_s = tick_s ? (wcnt_r + 12'd1) : wcnt_r;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        wcnt_s  = 12'd0;
                        state_s = ST_HIGH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    wcnt_s = wcnt_inc_s;
                    if (fall_s) begin
                        accept_s = (wcnt_inc_s >= MIN_W) && (wcnt_inc_s <= MAX_W);
                        state_s  = ST_IDLE;
                    end else if (wcnt_inc_s > MAX_W) begin
                        state_s = ST_WAIT_LOW;
                    end else begin
                        state_s = ST_HIGH;
                    end
                end
                ST_WAIT_LOW: begin
                    if (fall_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT_LOW;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        // Saturating loss-of-signal counter
        always_comb begin
            to_cnt_s = to_cnt_r;
            if (tick_s && (to_cnt_r != TO_MAX)) begin
                to_cnt_s = to_cnt_r + 16'd1;
            end else begin
                to_cnt_s = to_cnt_r;
            end
        end

        // FSM state, counters and published width/strobe/valid
        always_ff @(posedge CLK) begin
            if (RST) begin
                state_r  <= ST_IDLE;
                wcnt_r   <= 12'd0;
                to_cnt_r <= 16'd0;
                width_r  <= 12'd0;
                new_r    <= 1'b0;
                valid_r  <= 1'b0;
            end else begin
                state_r <= state_s;
                wcnt_r  <= wcnt_s;
                new_r   <= accept_s;
                if (accept_s) begin
                    width_r  <= wcnt_inc_s;
                    valid_r  <= 1'b1;
                    to_cnt_r <= 16'd0;
                end else begin
                    to_cnt_r <= to_cnt_s;
                    if (to_cnt_s == TO_MAX) begin
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
            end
        end
    end

endmodule
